// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the SPARC8 decode stage and the hazard/stall controller.
// master = pipeline side (drives stage fields), slave = hazard_stall_unit.
interface hazard_stall_unit_if;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic        ID_use_rs1, ID_use_rs2, ID_use_rd;
  logic        ID_Branch_CC;
  logic [4:0]  EX_rd, MEM_rd, WB_rd;
  logic        EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable;
  logic        EX_Load_Instr;
  logic        EX_Instr_Alter_CC;
  logic        ID_flush;
  logic        ctrl_mux_select;
  logic        PC_LE, nPC_LE, IF_ID_LE;
  logic [1:0]  fwd_A, fwd_B, fwd_C;
  logic [15:0] stall_count;

  modport master (
    output ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2, ID_use_rd, ID_Branch_CC,
           EX_rd, MEM_rd, WB_rd, EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
           EX_Load_Instr, EX_Instr_Alter_CC, ID_flush,
    input  ctrl_mux_select, PC_LE, nPC_LE, IF_ID_LE, fwd_A, fwd_B, fwd_C, stall_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2, ID_use_rd, ID_Branch_CC,
           EX_rd, MEM_rd, WB_rd, EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
           EX_Load_Instr, EX_Instr_Alter_CC, ID_flush,
    output ctrl_mux_select, PC_LE, nPC_LE, IF_ID_LE, fwd_A, fwd_B, fwd_C, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// SPARC8 ID-stage hazard controller: bubble select, PC/nPC/IF_ID load enables and
// forwarding selects. Define HAZARD_FORWARD_EN to enable operand forwarding.
module hazard_stall_unit #(
  parameter int unsigned STARTUP_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  hazard_stall_unit_if.slave hz
);

  localparam int NUM_OPS = 3;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [NUM_OPS-1:0][4:0] src;
  logic [NUM_OPS-1:0]      use_v;
  logic [NUM_OPS-1:0]      ex_hit, mem_hit;
  logic [NUM_OPS-1:0][1:0] fwd_raw;
  logic                    cc_haz;
  logic [1:0]              need;
  logic                    stall;

  assign src   = {hz.ID_rd, hz.ID_rs2, hz.ID_rs1};
  assign use_v = {hz.ID_use_rd, hz.ID_use_rs2, hz.ID_use_rs1};

  // Per-operand comparators; %r0 and unused operands never match.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic live, ex_m, mem_m, wb_m;
    assign live  = use_v[g] && (src[g] != 5'd0);
    assign ex_m  = live && hz.EX_RF_Enable  && (hz.EX_rd  == src[g]);
    assign mem_m = live && hz.MEM_RF_Enable && (hz.MEM_rd == src[g]);
    assign wb_m  = live && hz.WB_RF_Enable  && (hz.WB_rd  == src[g]);
    assign ex_hit[g]  = ex_m;
    assign mem_hit[g] = mem_m;
    // Load data is not available in EX, so a load never forwards from there.
    assign fwd_raw[g] = (ex_m && !hz.EX_Load_Instr) ? 2'b01 :
                        mem_m                       ? 2'b10 :
                        wb_m                        ? 2'b11 : 2'b00;
  end

  assign cc_haz = hz.ID_Branch_CC && hz.EX_Instr_Alter_CC;

`ifdef HAZARD_FORWARD_EN
  logic unused_mem_hit;
  assign unused_mem_hit = ^mem_hit;
  assign need = (((|ex_hit) && hz.EX_Load_Instr) || cc_haz) ? 2'd1 : 2'd0;
`else
  logic unused_fwd;
  assign unused_fwd = ^fwd_raw;
  assign need = (|ex_hit)             ? 2'd2 :
                ((|mem_hit) || cc_haz) ? 2'd1 : 2'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= 4'(STARTUP_CYCLES);
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        stall = 1'b1;
        if (cnt_q <= 4'd1) state_d = S_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RUN: begin
        if (!hz.ID_flush && need != 2'd0) begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_d = S_STALL;
            cnt_d   = 4'd1;
          end
        end
      end
      S_STALL: begin
        // A flush squashes the held instruction, so the remaining bubbles are moot.
        if (hz.ID_flush) begin
          state_d = S_RUN;
        end else begin
          stall = 1'b1;
          if (cnt_q <= 4'd1) state_d = S_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        stall   = 1'b1;
        state_d = S_INIT;
        cnt_d   = 4'(STARTUP_CYCLES);
      end
    endcase
  end

  assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

  assign hz.ctrl_mux_select = ~stall;
  assign hz.PC_LE           = ~stall;
  assign hz.nPC_LE          = ~stall;
  assign hz.IF_ID_LE        = ~stall;
  assign hz.stall_count     = stall_cnt_q;

`ifdef HAZARD_FORWARD_EN
  assign hz.fwd_A = (state_q == S_INIT) ? 2'b00 : fwd_raw[0];
  assign hz.fwd_B = (state_q == S_INIT) ? 2'b00 : fwd_raw[1];
  assign hz.fwd_C = (state_q == S_INIT) ? 2'b00 : fwd_raw[2];
`else
  assign hz.fwd_A = 2'b00;
  assign hz.fwd_B = 2'b00;
  assign hz.fwd_C = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for single-cycle cases,
// hand sequences for startup, multi-cycle stalls, flush, async reset and saturation.
module tb_hazard_stall_unit;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_unit_if hz();
  hazard_stall_unit #(.STARTUP_CYCLES(2)) dut (.clk(clk), .reset(reset), .hz(hz));

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_sc = 16'd0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, u3, bcc;
    logic [4:0] exrd, memrd, wbrd;
    logic       exen, memen, wben, exld, excc, flush;
    logic       esel;
    logic [1:0] fa, fb, fc;
  } vec_t;

  vec_t vt[11];

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    hz.ID_rs1 = 0; hz.ID_rs2 = 0; hz.ID_rd = 0;
    hz.ID_use_rs1 = 0; hz.ID_use_rs2 = 0; hz.ID_use_rd = 0; hz.ID_Branch_CC = 0;
    hz.EX_rd = 0; hz.MEM_rd = 0; hz.WB_rd = 0;
    hz.EX_RF_Enable = 0; hz.MEM_RF_Enable = 0; hz.WB_RF_Enable = 0;
    hz.EX_Load_Instr = 0; hz.EX_Instr_Alter_CC = 0; hz.ID_flush = 0;
  endtask

  task automatic apply(vec_t v);
    hz.ID_rs1 = v.rs1; hz.ID_rs2 = v.rs2; hz.ID_rd = v.rd;
    hz.ID_use_rs1 = v.u1; hz.ID_use_rs2 = v.u2; hz.ID_use_rd = v.u3; hz.ID_Branch_CC = v.bcc;
    hz.EX_rd = v.exrd; hz.MEM_rd = v.memrd; hz.WB_rd = v.wbrd;
    hz.EX_RF_Enable = v.exen; hz.MEM_RF_Enable = v.memen; hz.WB_RF_Enable = v.wben;
    hz.EX_Load_Instr = v.exld; hz.EX_Instr_Alter_CC = v.excc; hz.ID_flush = v.flush;
  endtask

  // Inputs are set at a falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(string nm, logic es, logic [1:0] fa, logic [1:0] fb, logic [1:0] fc);
    #1;
    chk({nm, ".sel"},   16'(hz.ctrl_mux_select), 16'(es));
    chk({nm, ".le"},    16'({hz.PC_LE, hz.nPC_LE, hz.IF_ID_LE}), es ? 16'd7 : 16'd0);
    chk({nm, ".fwd"},   16'({hz.fwd_A, hz.fwd_B, hz.fwd_C}), 16'({fa, fb, fc}));
    chk({nm, ".count"}, hz.stall_count, exp_sc);
    if (!es && exp_sc != 16'hFFFF) exp_sc++;
    @(negedge clk);
  endtask

  task automatic startup(string nm);
    @(negedge clk);
    reset = 1'b0;
    exp_sc = 16'd0;
    cyc({nm, ".b0"}, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc({nm, ".b1"}, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc({nm, ".run"}, 1'b1, 2'b00, 2'b00, 2'b00);
    chk({nm, ".count2"}, hz.stall_count, 16'd2);
  endtask

  initial begin
    //       rs1 rs2 rd u1 u2 u3 bcc exrd memrd wbrd exen memen wben exld excc flush esel fa fb fc
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 2'b00};
    vt[1]  = '{3, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, FWD, FWD ? 2'b10 : 2'b00, 2'b00, 2'b00};
    vt[2]  = '{0, 4, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1'b1, 2'b00, FWD ? 2'b11 : 2'b00, 2'b00};
    vt[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1'b1, 2'b00, 2'b00, 2'b00};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1'b0, 2'b00, 2'b00, 2'b00};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 2'b00};
    vt[6]  = '{3, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 1'b1, FWD ? 2'b10 : 2'b00, 2'b00, 2'b00};
    vt[7]  = '{0, 0, 6, 0, 0, 1, 0, 0, 6, 6, 0, 0, 1, 0, 0, 0, 1'b1, 2'b00, 2'b00, FWD ? 2'b11 : 2'b00};
    vt[8]  = '{9, 0, 0, 1, 0, 0, 0, 0, 9, 9, 0, 1, 1, 0, 0, 0, FWD, FWD ? 2'b10 : 2'b00, 2'b00, 2'b00};
    vt[9]  = '{12, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 1'b1, 2'b00, 2'b00, 2'b00};
    vt[10] = '{0, 8, 0, 0, 1, 0, 0, 8, 8, 0, 0, 1, 0, 0, 0, 0, FWD, 2'b00, FWD ? 2'b10 : 2'b00, 2'b00};

    clr();
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst.sel", 16'(hz.ctrl_mux_select), 16'd0);
    chk("rst.le", 16'({hz.PC_LE, hz.nPC_LE, hz.IF_ID_LE}), 16'd0);
    chk("rst.fwd", 16'({hz.fwd_A, hz.fwd_B, hz.fwd_C}), 16'd0);
    chk("rst.count", hz.stall_count, 16'd0);
    startup("start");

    for (int i = 0; i < 11; i++) begin
      apply(vt[i]);
      cyc($sformatf("vec%0d", i), vt[i].esel, vt[i].fa, vt[i].fb, vt[i].fc);
    end

`ifdef HAZARD_FORWARD_EN
    clr(); hz.ID_rs1 = 5; hz.ID_use_rs1 = 1; hz.EX_rd = 5; hz.EX_RF_Enable = 1; hz.EX_Load_Instr = 1;
    cyc("lduse.bubble", 1'b0, 2'b00, 2'b00, 2'b00);
    clr(); hz.ID_rs1 = 5; hz.ID_use_rs1 = 1; hz.MEM_rd = 5; hz.MEM_RF_Enable = 1;
    cyc("lduse.fwd", 1'b1, 2'b10, 2'b00, 2'b00);
    clr(); hz.ID_rs1 = 2; hz.ID_use_rs1 = 1; hz.EX_rd = 2; hz.EX_RF_Enable = 1;
    hz.MEM_rd = 2; hz.MEM_RF_Enable = 1;
    cyc("exfwd.prio", 1'b1, 2'b01, 2'b00, 2'b00);
    clr(); hz.ID_rs1 = 7; hz.ID_use_rs1 = 1; hz.EX_rd = 7; hz.EX_RF_Enable = 1;
    cyc("stallseq", 1'b1, 2'b01, 2'b00, 2'b00);
`else
    clr(); hz.ID_rs1 = 7; hz.ID_use_rs1 = 1; hz.EX_rd = 7; hz.EX_RF_Enable = 1;
    cyc("ex2.b0", 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("ex2.b1", 1'b0, 2'b00, 2'b00, 2'b00);
    clr(); hz.ID_rs1 = 7; hz.ID_use_rs1 = 1; hz.WB_rd = 7; hz.WB_RF_Enable = 1;
    cyc("ex2.pass", 1'b1, 2'b00, 2'b00, 2'b00);

    clr(); hz.ID_rs1 = 7; hz.ID_use_rs1 = 1; hz.EX_rd = 7; hz.EX_RF_Enable = 1;
    cyc("flush.b0", 1'b0, 2'b00, 2'b00, 2'b00);
    hz.ID_flush = 1;
    cyc("flush.abort", 1'b1, 2'b00, 2'b00, 2'b00);
    clr();
    cyc("flush.run", 1'b1, 2'b00, 2'b00, 2'b00);

    // Held hazard re-fires in RUN; the STALL cycle then ignores the cleared inputs.
    clr(); hz.ID_rs2 = 11; hz.ID_use_rs2 = 1; hz.EX_rd = 11; hz.EX_RF_Enable = 1;
    cyc("reeval.b0", 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("reeval.b1", 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("reeval.b2", 1'b0, 2'b00, 2'b00, 2'b00);
    clr();
    cyc("reeval.b3", 1'b0, 2'b00, 2'b00, 2'b00);
    cyc("reeval.run", 1'b1, 2'b00, 2'b00, 2'b00);

    clr(); hz.ID_rs1 = 7; hz.ID_use_rs1 = 1; hz.EX_rd = 7; hz.EX_RF_Enable = 1;
    cyc("stallseq", 1'b0, 2'b00, 2'b00, 2'b00);
`endif

    // Asynchronous reset mid-cycle (in STALL for the default build).
    #2;
    reset = 1'b1;
    #1;
    chk("areset.sel", 16'(hz.ctrl_mux_select), 16'd0);
    chk("areset.le", 16'({hz.PC_LE, hz.nPC_LE, hz.IF_ID_LE}), 16'd0);
    chk("areset.count", hz.stall_count, 16'd0);
    clr();
    startup("restart");

    // Saturation: hold a CC hazard far past 16 bits of bubbles.
    hz.ID_Branch_CC = 1; hz.EX_Instr_Alter_CC = 1;
    for (int i = 0; i < 65540; i++) @(negedge clk);
    exp_sc = 16'hFFFF;
    cyc("sat", 1'b0, 2'b00, 2'b00, 2'b00);
    #1;
    chk("sat.hold", hz.stall_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
